wave_synth: RTL

WAVE_SYNTH -- requirements
Module: wave_synth

---
 rtl/wave_synth_pkg.sv | 27 ++
 rtl/wave_sine_lut.sv | 32 +++
 rtl/wave_synth.sv | 127 ++++++++++++
 3 files changed

// File: rtl/wave_synth_pkg.sv
// Shared definitions for the wave_synth DDS block: waveform codes and the
// quarter-wave sine magnitude table (used only when WAVE_SYNTH_SINE_LUT_EN is defined).
package wave_synth_pkg;

    typedef enum logic [1:0] {
        WaveSquare = 2'b00,
        WaveSaw    = 2'b01,
        WaveTri    = 2'b10,
        WaveSine   = 2'b11
    } wave_e;

    localparam int unsigned SineLutDepth = 64;

    // round(127 * sin((i + 0.5) * pi / 128)); the half-step offset makes the
    // mirrored quadrants exactly symmetric.
    localparam logic [6:0] SineQuarter [SineLutDepth] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

endpackage

// File: rtl/wave_sine_lut.sv
// Combinational quarter-wave sine lookup. phase_bits are the top 8 phase bits:
// [7:6] select the quadrant, [5:0] index the quarter table. Supports N up to 16
// by scaling the 7-bit table magnitude into N-1 bits.
module wave_sine_lut
    import wave_synth_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [7:0]          phase_bits,
    output logic signed [N-1:0] sample
);

    logic [5:0]   addr;
    logic [6:0]   mag;
    logic [N-1:0] mag_n;

    // Mirror the index in the second and fourth quadrants.
    always_comb begin
        addr = phase_bits[6] ? ~phase_bits[5:0] : phase_bits[5:0];
        mag  = SineQuarter[addr];
    end

    if (N >= 8) begin : gen_scale_up
        assign mag_n = {{(N - 7){1'b0}}, mag} << (N - 8);
    end else begin : gen_scale_down
        assign mag_n = {1'b0, mag[6 -: (N - 1)]};
    end

    // Negative half-period in the third and fourth quadrants.
    assign sample = phase_bits[7] ? $signed(-mag_n) : $signed(mag_n);

endmodule

// File: rtl/wave_synth.sv
// Phase-accumulator waveform synthesiser with phase-continuous, wrap-aligned
// reconfiguration. Optional sine output: define WAVE_SYNTH_SINE_LUT_EN.
module wave_synth
    import wave_synth_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned PW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [PW-1:0]        cfg_fword,
    input  logic [1:0]           cfg_wave,
    input  logic [2:0]           cfg_shift,
    output logic signed [N-1:0]  sample_out,
    output logic                 sample_valid,
    output logic                 sync_out
);

    localparam logic signed [N-1:0] SqPos = {1'b0, {(N - 1){1'b1}}};
    localparam logic signed [N-1:0] SqNeg = {1'b1, {(N - 1){1'b0}}};

    logic [PW-1:0]        phase_q;
    logic [PW-1:0]        fword_act_q, fword_sh_q;
    wave_e                wave_act_q, wave_sh_q;
    logic [2:0]           shift_act_q, shift_sh_q;
    logic                 pending_q;
    logic signed [N-1:0]  sample_q;
    logic                 valid_q, sync_q;

    logic [PW-1:0]        phase_sum;
    logic                 carry, wrap, accept, apply;
    wave_e                wave_sel;
    logic [2:0]           shift_sel;
    logic [N-1:0]         tri_t;
    logic signed [N-1:0]  raw, shaped;
    logic                 unused_phase;

`ifdef WAVE_SYNTH_SINE_LUT_EN
    logic signed [N-1:0]  sine_val;

    wave_sine_lut #(
        .N (N)
    ) u_sine_lut (
        .phase_bits (phase_sum[PW-1 -: 8]),
        .sample     (sine_val)
    );
`endif

    // Next phase, config hand-off decisions and waveform shaping of the updated phase.
    always_comb begin
        {carry, phase_sum} = {1'b0, phase_q} + {1'b0, fword_act_q};
        wrap   = en & carry;
        accept = cfg_valid & ~pending_q;
        // Idle: hand over immediately; running: only on a wrap edge.
        apply  = pending_q & (~en | carry);
        // The wrap sample already belongs to the new configuration's first period.
        wave_sel  = apply ? wave_sh_q  : wave_act_q;
        shift_sel = apply ? shift_sh_q : shift_act_q;
        tri_t     = phase_sum[PW-2 -: N];
        raw       = '0;
        unique case (wave_sel)
            WaveSquare: raw = phase_sum[PW-1] ? SqNeg : SqPos;
            WaveSaw:    raw = {~phase_sum[PW-1], phase_sum[PW-2 -: (N - 1)]};
            WaveTri:    raw = phase_sum[PW-1] ? {tri_t[N-1], ~tri_t[N-2:0]}
                                              : {~tri_t[N-1], tri_t[N-2:0]};
`ifdef WAVE_SYNTH_SINE_LUT_EN
            WaveSine:   raw = sine_val;
`else
            WaveSine:   raw = '0;
`endif
            default:    raw = '0;
        endcase
        shaped = raw >>> shift_sel;
    end

    // Low phase bits only feed the carry chain.
    assign unused_phase = ^phase_sum;

    // Configuration shadow/active registers and the pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fword_act_q <= '0;
            wave_act_q  <= WaveSquare;
            shift_act_q <= '0;
            fword_sh_q  <= '0;
            wave_sh_q   <= WaveSquare;
            shift_sh_q  <= '0;
            pending_q   <= 1'b0;
        end else if (accept) begin
            fword_sh_q  <= cfg_fword;
            wave_sh_q   <= wave_e'(cfg_wave);
            shift_sh_q  <= cfg_shift;
            pending_q   <= 1'b1;
        end else if (apply) begin
            fword_act_q <= fword_sh_q;
            wave_act_q  <= wave_sh_q;
            shift_act_q <= shift_sh_q;
            pending_q   <= 1'b0;
        end
    end

    // Phase accumulator and registered sample outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            valid_q <= en;
            sync_q  <= wrap;
            if (en) begin
                phase_q  <= phase_sum;
                sample_q <= shaped;
            end
        end
    end

    assign cfg_ready    = ~pending_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign sync_out     = sync_q;

endmodule
